pwm_ramp_sequencer: RTL and testbench

Sequences the 8-bit duty-cycle input of the PWM output peripheral, so firmware does not have to write every duty step itself.
- One-shot mode: ramps duty from its current value to a target, with a programmable step size and step interval.
- Breathe mode: oscillates duty continuously between the start value and the target.
- Configured through a valid/ready handshake. Reports busy and done. Sits between the register file and the PWM peripheral's duty input.

---
 rtl/pwm_ramp_sequencer.sv | 143 ++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// Duty-cycle ramp sequencer for the PWM peripheral: one-shot ramps to a target
// or breathes between two endpoints, stepping once every N prescaler ticks.
module pwm_ramp_sequencer #(
    parameter int TICK_DIV = 3328,
    parameter int TICK_W   = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_target,
    input  logic [7:0] cfg_step,
    input  logic [7:0] cfg_interval,
    input  logic       cfg_mode,
    input  logic       abort,
    output logic [7:0] duty,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t            r_state, w_state_nxt;
    logic [TICK_W-1:0] r_presc;
    logic [7:0]        r_duty, w_duty_nxt;
    logic [7:0]        r_target, w_target_nxt;
    logic [7:0]        r_base, w_base_nxt;
    logic [7:0]        r_step, w_step_nxt;
    logic [7:0]        r_interval, w_interval_nxt;
    logic [7:0]        r_icnt, w_icnt_nxt;
    logic              r_mode, w_mode_nxt;
    logic              r_dir_up, w_dir_up_nxt;
    logic              r_done, w_done_nxt;

    logic              w_tick;
    logic [8:0]        w_sum, w_diff;
    logic [7:0]        w_up_val, w_dn_val, w_step_val, w_icnt_inc;
    logic              w_step_due;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_presc <= '0;
        else if (r_presc == TICK_LAST) r_presc <= '0;
        else                        r_presc <= r_presc + TICK_W'(1);
    end

    assign w_tick = (r_presc == TICK_LAST);

    // 9-bit arithmetic so overflow/borrow clamps to the target instead of wrapping.
    assign w_sum      = {1'b0, r_duty} + {1'b0, r_step};
    assign w_diff     = {1'b0, r_duty} - {1'b0, r_step};
    assign w_up_val   = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[7:0];
    assign w_dn_val   = (w_diff[8] || (w_diff[7:0] <= r_target)) ? r_target : w_diff[7:0];
    assign w_step_val = r_dir_up ? w_up_val : w_dn_val;
    assign w_icnt_inc = r_icnt + 8'd1;
    assign w_step_due = w_tick && (w_icnt_inc == r_interval);

    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_target_nxt   = r_target;
        w_base_nxt     = r_base;
        w_step_nxt     = r_step;
        w_interval_nxt = r_interval;
        w_icnt_nxt     = r_icnt;
        w_mode_nxt     = r_mode;
        w_dir_up_nxt   = r_dir_up;
        w_done_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_target_nxt   = cfg_target;
                    w_step_nxt     = (cfg_step == 8'd0) ? 8'd1 : cfg_step;
                    w_interval_nxt = (cfg_interval == 8'd0) ? 8'd1 : cfg_interval;
                    w_mode_nxt     = cfg_mode;
                    w_base_nxt     = r_duty;
                    w_dir_up_nxt   = (cfg_target > r_duty);
                    w_icnt_nxt     = 8'd0;
                    if ((cfg_target == r_duty) && !cfg_mode) w_done_nxt  = 1'b1;
                    else                                     w_state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_icnt_nxt  = 8'd0;
                end else if (w_step_due) begin
                    w_icnt_nxt = 8'd0;
                    w_duty_nxt = w_step_val;
                    if (w_step_val == r_target) begin
                        if (r_mode) begin
                            w_target_nxt = r_base;
                            w_base_nxt   = r_target;
                            w_dir_up_nxt = !r_dir_up;
                        end else begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end else if (w_tick) begin
                    w_icnt_nxt = w_icnt_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_duty     <= 8'd0;
            r_target   <= 8'd0;
            r_base     <= 8'd0;
            r_step     <= 8'd1;
            r_interval <= 8'd1;
            r_icnt     <= 8'd0;
            r_mode     <= 1'b0;
            r_dir_up   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_target   <= w_target_nxt;
            r_base     <= w_base_nxt;
            r_step     <= w_step_nxt;
            r_interval <= w_interval_nxt;
            r_icnt     <= w_icnt_nxt;
            r_mode     <= w_mode_nxt;
            r_dir_up   <= w_dir_up_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state == RAMP);
    assign duty      = r_duty;
    assign done      = r_done;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer with TICK_DIV=4: ramps, clamping,
// breathe mode, abort, boundary configs and asynchronous reset.
module tb_pwm_ramp_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_target;
    logic [7:0] cfg_step;
    logic [7:0] cfg_interval;
    logic       cfg_mode;
    logic       abort;
    logic [7:0] duty;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int t_last, t_now, el;

    logic [7:0] exp2 [4] = '{8'd30, 8'd60, 8'd90, 8'd100};
    logic [7:0] exp3 [3] = '{8'd60, 8'd20, 8'd5};
    logic [7:0] exp4 [5] = '{8'd30, 8'd50, 8'd30, 8'd10, 8'd30};
    logic [7:0] exp5 [3] = '{8'd1, 8'd2, 8'd3};

    pwm_ramp_sequencer #(.TICK_DIV(4), .TICK_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_target   (cfg_target),
        .cfg_step     (cfg_step),
        .cfg_interval (cfg_interval),
        .cfg_mode     (cfg_mode),
        .abort        (abort),
        .duty         (duty),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) at negedges until duty changes; returns cycles waited.
    task automatic wait_change(input string tag, output int elapsed);
        logic [7:0] prev;
        prev    = duty;
        elapsed = 0;
        while ((duty === prev) && (elapsed < 60)) begin
            @(negedge clk);
            elapsed++;
        end
        if (elapsed >= 60) begin
            n_checks++;
            n_err++;
            $error("FAIL %s_timeout observed=%0d expected=<60", tag, elapsed);
        end
    endtask

    task automatic do_cfg(input logic [7:0] t, input logic [7:0] s, input logic [7:0] iv,
                          input logic m);
        cfg_target   = t;
        cfg_step     = s;
        cfg_interval = iv;
        cfg_mode     = m;
        cfg_valid    = 1'b1;
        @(negedge clk);
        cfg_valid    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
        cfg_target = 8'd0; cfg_step = 8'd0; cfg_interval = 8'd0; cfg_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_duty", duty, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cfg_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // One-shot up ramp 0 -> 100, step 30, interval 2 (8 clocks per step)
        do_cfg(8'd100, 8'd30, 8'd2, 1'b0);
        check("t2_busy", busy, 1);
        check("t2_ready", cfg_ready, 0);
        t_last = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_change("t2", el);
            t_now = cyc;
            check("t2_duty", duty, exp2[i]);
            check("t2_done", done, (i == 3) ? 1 : 0);
            if (i > 0) check("t2_spacing", t_now - t_last, 8);
            t_last = t_now;
        end
        check("t2_busy_end", busy, 0);
        check("t2_ready_end", cfg_ready, 1);
        @(negedge clk);
        check("t2_done_pulse", done, 0);
        check("t2_done_cnt", done_cnt, 1);

        // Down ramp with borrow clamp
        do_cfg(8'd5, 8'd40, 8'd1, 1'b0);
        t_last = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_change("t3", el);
            t_now = cyc;
            check("t3_duty", duty, exp3[i]);
            if (i > 0) check("t3_spacing", t_now - t_last, 4);
            t_last = t_now;
        end
        check("t3_done", done, 1);
        do_cfg(8'd250, 8'd255, 8'd1, 1'b0);
        wait_change("t3b", el);
        check("t3_duty250", duty, 250);
        do_cfg(8'd255, 8'd10, 8'd1, 1'b0);
        wait_change("t3c", el);
        check("t3_duty255", duty, 255);
        check("t3c_done", done, 1);
        check("t3c_busy", busy, 0);
        check("t3_done_cnt", done_cnt, 4);

        // Breathe between 10 and 50, then abort
        do_cfg(8'd10, 8'd255, 8'd1, 1'b0);
        wait_change("t4a", el);
        check("t4_duty10", duty, 10);
        do_cfg(8'd50, 8'd20, 8'd1, 1'b1);
        t_last = cyc;
        for (int i = 0; i < 5; i++) begin
            wait_change("t4", el);
            t_now = cyc;
            check("t4_duty", duty, exp4[i]);
            check("t4_busy", busy, 1);
            if (i > 0) check("t4_spacing", t_now - t_last, 4);
            t_last = t_now;
        end
        check("t4_no_done", done_cnt, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort_duty", duty, 30);
        check("t4_abort_busy", busy, 0);
        check("t4_abort_ready", cfg_ready, 1);
        check("t4_abort_done", done, 0);
        repeat (12) @(negedge clk);
        check("t4_hold_duty", duty, 30);
        check("t4_done_cnt", done_cnt, 5);

        // Boundary configs: step=0, interval=0; ignored cfg while busy; target == duty
        do_cfg(8'd0, 8'd255, 8'd1, 1'b0);
        wait_change("t5a", el);
        check("t5_duty0", duty, 0);
        do_cfg(8'd3, 8'd0, 8'd0, 1'b0);
        t_last = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_change("t5", el);
            t_now = cyc;
            check("t5_duty", duty, exp5[i]);
            if (i > 0) check("t5_spacing", t_now - t_last, 4);
            t_last = t_now;
            if (i == 0) begin
                check("t5_ready_busy", cfg_ready, 0);
                cfg_target = 8'd50; cfg_step = 8'd255; cfg_interval = 8'd1;
                cfg_mode = 1'b0; cfg_valid = 1'b1;
                @(negedge clk);
                cfg_valid = 1'b0;
            end
        end
        check("t5_done", done, 1);
        check("t5_done_cnt", done_cnt, 7);
        do_cfg(8'd3, 8'd7, 8'd9, 1'b0);
        check("t5_eq_done", done, 1);
        check("t5_eq_duty", duty, 3);
        check("t5_eq_busy", busy, 0);
        @(negedge clk);
        check("t5_eq_done_off", done, 0);
        check("t5_eq_done_cnt", done_cnt, 8);

        // Abort coinciding with a scheduled step; cfg_valid with abort in IDLE
        do_cfg(8'd200, 8'd10, 8'd1, 1'b0);
        wait_change("t6", el);
        check("t6_duty13", duty, 13);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_abort_duty", duty, 13);
        check("t6_abort_busy", busy, 0);
        cfg_target = 8'd0; cfg_step = 8'd255; cfg_interval = 8'd1; cfg_mode = 1'b0;
        cfg_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; abort = 1'b0;
        check("t6_accept_busy", busy, 1);
        wait_change("t6b", el);
        check("t6b_duty", duty, 0);
        check("t6b_done", done, 1);

        // Asynchronous reset in the middle of a ramp
        do_cfg(8'd100, 8'd30, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) wait_change("t1", el);
        check("t1_duty90", duty, 90);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_duty", duty, 0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_done", done, 0);
        check("t1_rst_ready", cfg_ready, 1);
        check("t1_rst_presc", dut.r_presc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_presc_restart", dut.r_presc, 1);
        check("t1_post_duty", duty, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
